store_port: RTL

// Posted-write buffer between the write stage's memory request (address_enable/address/data/data_valid)
// and the external data bus. Accepts one store per cycle while not full and acknowledges it at once,
// so the write stage stalls only when the buffer is full. Drains stores in order onto a

---
 rtl/store_port_pkg.sv | 16 +
 rtl/store_fifo.sv | 69 ++++++
 rtl/store_port.sv | 87 ++++++++
 3 files changed

// File: rtl/store_port_pkg.sv
// Shared types and defaults for the posted-write store port.
package store_port_pkg;

  // Architectural register width used for store addresses and data.
  typedef logic [31:0] regval_t;

  // Default number of buffered stores.
  localparam int StorePortDepth = 4;

  // One buffered store as it sits in the posted-write queue.
  typedef struct packed {
    regval_t address;
    regval_t data;
  } store_entry_t;

endpackage

// File: rtl/store_fifo.sv
// In-order queue of pending stores with an occupancy count that tells
// full from empty, so the pointers can stay log2(DEPTH) bits and simply wrap.
module store_fifo
  import store_port_pkg::*;
#(
  parameter int  DEPTH = StorePortDepth,
  parameter type T     = store_entry_t
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  T                       push_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output T                       head
);

  localparam int PtrW = $clog2(DEPTH);
  localparam int CntW = PtrW + 1;

  T                mem_q [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push;
  logic            do_pop;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];

  // Next pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; reset empties the queue and discards whatever was buffered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are meaningless while count is zero, so no reset.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/store_port.sv
// Posted-write buffer between the write stage and a waitrequest-style bus.
// Stores are acknowledged on acceptance and drained strictly in order; a
// store stuck on the bus for TIMEOUT wait cycles raises a sticky bus_error
// that freezes both the accept and drain sides until reset.
module store_port
  import store_port_pkg::*;
#(
  parameter int DEPTH   = StorePortDepth,
  parameter int TIMEOUT = 255
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   address_enable,
  input  regval_t                address,
  input  regval_t                data,
  output logic                   data_valid,
  output logic                   bus_write,
  output regval_t                bus_address,
  output regval_t                bus_writedata,
  input  logic                   bus_waitrequest,
  output logic [$clog2(DEPTH):0] count,
  output logic                   idle,
  output logic                   bus_error
);

  // A zero TIMEOUT disables the watchdog; the counter then just saturates.
  localparam int               WaitW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WaitW-1:0] WaitLast = (TIMEOUT > 0) ? WaitW'(TIMEOUT - 1) : '0;

  store_entry_t     push_entry;
  store_entry_t     head_entry;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             bus_error_q, bus_error_d;

  assign push_entry    = store_entry_t'{address: address, data: data};
  assign data_valid    = address_enable && !fifo_full && !bus_error_q;
  assign bus_write     = !fifo_empty && !bus_error_q;
  assign pop           = bus_write && !bus_waitrequest;
  assign bus_address   = head_entry.address;
  assign bus_writedata = head_entry.data;
  assign idle          = fifo_empty && !address_enable;
  assign bus_error     = bus_error_q;

  store_fifo #(
    .DEPTH (DEPTH),
    .T     (store_entry_t)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (data_valid),
    .pop       (pop),
    .push_data (push_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count),
    .head      (head_entry)
  );

  // Count consecutive stalled cycles on the head store and flag the one that hits TIMEOUT.
  always_comb begin
    wait_d      = wait_q;
    bus_error_d = bus_error_q;
    if (!bus_write || pop) begin
      wait_d = '0;
    end else if (wait_q != '1) begin
      wait_d = wait_q + WaitW'(1);
    end
    if ((TIMEOUT != 0) && bus_write && bus_waitrequest && (wait_q == WaitLast)) begin
      bus_error_d = 1'b1;
    end
  end

  // Watchdog state; bus_error stays set until reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_q      <= '0;
      bus_error_q <= 1'b0;
    end else begin
      wait_q      <= wait_d;
      bus_error_q <= bus_error_d;
    end
  end

endmodule
